matrix_host_port: RTL and testbench
===================================

MATRIX_HOST_PORT -- requirements
Module: matrix_host_port

Interface
REQ-001 Parameter: MAX_SIZE, default 6, largest square matrix dimension served/collected.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 ld_en  input  1  host write strobe into operand buffers (accepted only in IDLE/DONE).
REQ-005 ld_sel  input  1  0=matrix A buffer, 1=matrix B buffer.
REQ-006 ld_addr  input  6  row-major element index (0..MAX_SIZE²-1).
REQ-007 ld_data  input  16  signed operand element.
REQ-008 sizes  input  4  active dimension N for the run.
REQ-009 go  input  1  host request to launch a multiply.
REQ-010 start  output  1  one-cycle launch pulse to the multiplier.
REQ-011 ren  input  1  multiplier read enable.
REQ-012 raddr  input  1  0=stream A, 1=stream B.
REQ-013 rdata  output  16  signed element served to multiplier.
REQ-014 wen  input  1  multiplier result-valid strobe.
REQ-015 wdata  input  32  signed result element.
REQ-016 finish  input  1  multiplier completion pulse.
REQ-017 res_addr  input  6  host read index into result buffer.
REQ-018 res_data  output  32  combinational read of result buffer at res_addr.
REQ-019 res_count  output  6  results captured this run.
REQ-020 busy  output  1  high in LAUNCH and RUN.
REQ-021 done  output  1  high in DONE.
REQ-022 err  output  1  sticky error flag, cleared on accepted go.

Function
REQ-023 FSM states IDLE, LAUNCH, RUN, DONE; IDLE->LAUNCH on go with 1<=sizes<=MAX_SIZE; LAUNCH->RUN after exactly one cycle; RUN->DONE on finish; DONE->LAUNCH on valid go.
REQ-024 go with sizes==0 or sizes>MAX_SIZE: no transition, err set.
REQ-025 start high exactly during the LAUNCH cycle, low otherwise.
REQ-026 Entering LAUNCH clears ptr_a, ptr_b, res_count, err.
REQ-027 rdata = bufA[ptr_a] when ren&&!raddr, bufB[ptr_b] when ren&&raddr, else 0; combinational from registered pointers so data is stable by the multiplier's negedge sample.
REQ-028 Each posedge in RUN with ren high increments the selected pointer by 1; pointers never wrap.
REQ-029 Pointer already at N²-1 with ren high: pointer holds, err set (overrun).
REQ-030 Each posedge in RUN with wen high writes wdata into result buffer at res_count and increments res_count.
REQ-031 wen with res_count==N²: write dropped, count holds, err set.
REQ-032 wen and finish in same cycle: write captured, then DONE.
REQ-033 ren/wen outside RUN ignored; ld_en during LAUNCH/RUN ignored, err set.
REQ-034 Operand buffers retain contents across runs; result buffer retains until overwritten.

Reset
REQ-035 rstn low: state IDLE, start=0, rdata=0, busy=0, done=0, err=0, res_count=0, pointers 0, all buffers zero; applies immediately mid-run.

Configuration
REQ-036 MATRIX_HOST_PORT_CHECK_EN defined: on finish, err set if res_count!=N² or either final pointer !=N²-1; undefined: no completion check, other err sources unchanged.

Structure
REQ-037 Shared package holds MAX_SIZE default, FSM state encodings, raddr codes (ADDR_A=0, ADDR_B=1).
REQ-038 One sub-module, matrix_host_buf: parameterised width/depth register array, one write port, two combinational read ports; instanced for A, B, result.

Verification
REQ-039 2x2: A=[1,2,3,4], B=identity, go -> start one cycle, rdata serves 1,2,3,4 then 1,0,0,1, captures 4 results, done=1, err=0.
REQ-040 go with sizes=7 -> state stays IDLE, start=0, err=1.
REQ-041 N=2, ren held 5 cycles on A -> ptr_a stops at 3, rdata stays A[3], err=1.
REQ-042 N=6 full run, wdata=-32768*32767 values -> res_data returns exact signed 32-bit values at addresses 0..35.
REQ-043 rstn pulsed mid-RUN -> outputs to reset values same cycle, next go runs cleanly.
REQ-044 CHECK_EN defined, finish after 3 of 4 wen (N=2) -> err=1; undefined -> err=0.

Source files
------------

// File: rtl/matrix_host_port_pkg.sv
// matrix_host_port_pkg
// Shared definitions for the matrix host port slice:
//   - MAX_SIZE_DEF : default largest square matrix dimension
//   - ST_*         : controller state encodings
//   - ADDR_A/B     : raddr stream select codes
//   - sq6()        : square of a dimension, truncated to the element index width
package matrix_host_port_pkg;

  localparam int MAX_SIZE_DEF = 6;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic ADDR_A = 1'b0;
  localparam logic ADDR_B = 1'b1;

  // Only ever used on validated dimensions, so the 6-bit result is exact.
  function automatic logic [5:0] sq6(input logic [3:0] n);
    logic [5:0] n6;
    n6 = {2'b00, n};
    return n6 * n6;
  endfunction

endpackage

// File: rtl/matrix_host_buf.sv
// matrix_host_buf
// Register-array buffer with one synchronous write port and two
// combinational read ports. Contents are zeroed by reset. Writes to an
// address at or beyond DEPTH are dropped; reads there return zero.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   we, waddr, wdata write port
//   raddr0 / rdata0  combinational read port 0
//   raddr1 / rdata1  combinational read port 1
module matrix_host_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 36,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr0,
  output logic [WIDTH-1:0] rdata0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          mem_reg[gi] <= '0;
        end else if (we && (int'(waddr) == gi)) begin
          mem_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  always_comb begin
    rdata0 = '0;
    rdata1 = '0;
    if (int'(raddr0) < DEPTH) rdata0 = mem_reg[raddr0];
    if (int'(raddr1) < DEPTH) rdata1 = mem_reg[raddr1];
  end

endmodule

// File: rtl/matrix_host_port.sv
// matrix_host_port
// Host-side port of a square matrix multiplier. The host loads operand
// matrices A and B, launches a run of dimension N, and reads results back.
// During a run the multiplier streams operands out through ren/raddr/rdata
// and pushes results in through wen/wdata, ending with finish.
// Ports:
//   clk, rstn                          clock, asynchronous active-low reset
//   ld_en, ld_sel, ld_addr, ld_data    host operand load (IDLE/DONE only)
//   sizes, go                          run dimension and launch request
//   start                              one-cycle launch pulse
//   ren, raddr, rdata                  operand stream to the multiplier
//   wen, wdata, finish                 result stream from the multiplier
//   res_addr, res_data, res_count      host result readback
//   busy, done, err                    status
// Build option: define MATRIX_HOST_PORT_CHECK_EN to flag incomplete runs
// (result count or final stream pointers short of N*N) at finish.
module matrix_host_port
  import matrix_host_port_pkg::*;
#(
  parameter int MAX_SIZE = MAX_SIZE_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ld_en,
  input  logic        ld_sel,
  input  logic [5:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic [3:0]  sizes,
  input  logic        go,
  output logic        start,
  input  logic        ren,
  input  logic        raddr,
  output logic [15:0] rdata,
  input  logic        wen,
  input  logic [31:0] wdata,
  input  logic        finish,
  input  logic [5:0]  res_addr,
  output logic [31:0] res_data,
  output logic [5:0]  res_count,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int         DEPTH = MAX_SIZE * MAX_SIZE;
  localparam logic [3:0] MAX_N = 4'(MAX_SIZE);

  logic [1:0] state_reg;
  logic [5:0] ptr_a_reg, ptr_b_reg;
  logic [5:0] ptr_a_next, ptr_b_next;
  // A stream has handed out its last element; a further read is an overrun.
  logic       ex_a_reg, ex_b_reg;
  logic       ex_a_next, ex_b_next;
  logic [5:0] res_count_reg, res_count_next;
  logic [5:0] nsq_reg, last_reg;
  logic       err_reg;

  logic       idle_like, in_run, go_ok, overrun, res_we, res_drop, check_fail;
  logic       a_we, b_we;
  logic [5:0] nsq_go;
  logic [15:0] a_rd, b_rd;
  logic [15:0] unused_a_rd1, unused_b_rd1;
  logic [31:0] unused_r_rd1;

  assign idle_like = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  assign in_run    = (state_reg == ST_RUN);
  assign go_ok     = go && (sizes != 4'd0) && (sizes <= MAX_N);
  assign nsq_go    = sq6(sizes);

  assign a_we = idle_like && ld_en && !ld_sel;
  assign b_we = idle_like && ld_en &&  ld_sel;

  // The last element of a stream is served without moving the pointer,
  // so a completed stream leaves its pointer parked on N*N-1.
  always_comb begin
    ptr_a_next = ptr_a_reg;
    ptr_b_next = ptr_b_reg;
    ex_a_next  = ex_a_reg;
    ex_b_next  = ex_b_reg;
    overrun    = 1'b0;
    if (in_run && ren) begin
      if (raddr == ADDR_A) begin
        if (ptr_a_reg == last_reg) begin
          overrun   = ex_a_reg;
          ex_a_next = 1'b1;
        end else begin
          ptr_a_next = ptr_a_reg + 6'd1;
        end
      end else begin
        if (ptr_b_reg == last_reg) begin
          overrun   = ex_b_reg;
          ex_b_next = 1'b1;
        end else begin
          ptr_b_next = ptr_b_reg + 6'd1;
        end
      end
    end
  end

  assign res_we         = in_run && wen && (res_count_reg != nsq_reg);
  assign res_drop       = in_run && wen && (res_count_reg == nsq_reg);
  assign res_count_next = res_we ? res_count_reg + 6'd1 : res_count_reg;

`ifdef MATRIX_HOST_PORT_CHECK_EN
  // Evaluated on post-update values so a result arriving with finish counts.
  assign check_fail = (res_count_next != nsq_reg) ||
                      (ptr_a_next != last_reg) || (ptr_b_next != last_reg);
`else
  assign check_fail = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      ptr_a_reg     <= '0;
      ptr_b_reg     <= '0;
      ex_a_reg      <= 1'b0;
      ex_b_reg      <= 1'b0;
      res_count_reg <= '0;
      nsq_reg       <= '0;
      last_reg      <= '0;
      err_reg       <= 1'b0;
    end else begin
      ptr_a_reg     <= ptr_a_next;
      ptr_b_reg     <= ptr_b_next;
      ex_a_reg      <= ex_a_next;
      ex_b_reg      <= ex_b_next;
      res_count_reg <= res_count_next;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (go_ok) begin
            state_reg     <= ST_LAUNCH;
            ptr_a_reg     <= '0;
            ptr_b_reg     <= '0;
            ex_a_reg      <= 1'b0;
            ex_b_reg      <= 1'b0;
            res_count_reg <= '0;
            err_reg       <= 1'b0;
            nsq_reg       <= nsq_go;
            last_reg      <= nsq_go - 6'd1;
          end else if (go) begin
            err_reg <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          state_reg <= ST_RUN;
          if (ld_en) err_reg <= 1'b1;
        end
        ST_RUN: begin
          if (ld_en || overrun || res_drop) err_reg <= 1'b1;
          if (finish) begin
            state_reg <= ST_DONE;
            if (check_fail) err_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  matrix_host_buf #(.WIDTH(16), .DEPTH(DEPTH), .AW(6)) u_buf_a (
    .clk    (clk),
    .rstn   (rstn),
    .we     (a_we),
    .waddr  (ld_addr),
    .wdata  (ld_data),
    .raddr0 (ptr_a_reg),
    .rdata0 (a_rd),
    .raddr1 (ld_addr),
    .rdata1 (unused_a_rd1)
  );

  matrix_host_buf #(.WIDTH(16), .DEPTH(DEPTH), .AW(6)) u_buf_b (
    .clk    (clk),
    .rstn   (rstn),
    .we     (b_we),
    .waddr  (ld_addr),
    .wdata  (ld_data),
    .raddr0 (ptr_b_reg),
    .rdata0 (b_rd),
    .raddr1 (ld_addr),
    .rdata1 (unused_b_rd1)
  );

  matrix_host_buf #(.WIDTH(32), .DEPTH(DEPTH), .AW(6)) u_buf_r (
    .clk    (clk),
    .rstn   (rstn),
    .we     (res_we),
    .waddr  (res_count_reg),
    .wdata  (wdata),
    .raddr0 (res_addr),
    .rdata0 (res_data),
    .raddr1 (res_count_reg),
    .rdata1 (unused_r_rd1)
  );

  always_comb begin
    rdata = '0;
    if (ren && (raddr == ADDR_A)) rdata = a_rd;
    else if (ren && (raddr == ADDR_B)) rdata = b_rd;
  end

  assign start     = (state_reg == ST_LAUNCH);
  assign busy      = (state_reg == ST_LAUNCH) || (state_reg == ST_RUN);
  assign done      = (state_reg == ST_DONE);
  assign err       = err_reg;
  assign res_count = res_count_reg;

endmodule

// File: tb/tb_matrix_host_port.sv
module tb_matrix_host_port;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ld_en = 1'b0, ld_sel = 1'b0;
  logic [5:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [3:0]  sizes = '0;
  logic        go = 1'b0;
  logic        start;
  logic        ren = 1'b0, raddr = 1'b0;
  logic [15:0] rdata;
  logic        wen = 1'b0;
  logic [31:0] wdata = '0;
  logic        finish = 1'b0;
  logic [5:0]  res_addr = '0;
  logic [31:0] res_data;
  logic [5:0]  res_count;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  matrix_host_port dut (
    .clk(clk), .rstn(rstn), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .sizes(sizes), .go(go), .start(start), .ren(ren),
    .raddr(raddr), .rdata(rdata), .wen(wen), .wdata(wdata), .finish(finish),
    .res_addr(res_addr), .res_data(res_data), .res_count(res_count),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 idle, 1 launch, 2 run, 3 done. Streams are tracked as
  // element-read counts; the element served is min(count, N*N-1).
  int m_ph = 0, m_n2 = 0, m_ra = 0, m_rb = 0, m_rc = 0;
  bit m_err = 1'b0;
  logic [15:0] m_a [36];
  logic [15:0] m_b [36];
  logic [31:0] m_r [36];

  function automatic int elem_of(input int cnt, input int n2);
    if (n2 == 0) return 0;
    return (cnt > n2 - 1) ? n2 - 1 : cnt;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ph = 0; m_n2 = 0; m_ra = 0; m_rb = 0; m_rc = 0; m_err = 1'b0;
      for (int i = 0; i < 36; i++) begin
        m_a[i] = '0; m_b[i] = '0; m_r[i] = '0;
      end
    end else begin
      case (m_ph)
        0, 3: begin
          if (ld_en && int'(ld_addr) < 36) begin
            if (ld_sel) m_b[ld_addr] = ld_data;
            else        m_a[ld_addr] = ld_data;
          end
          if (go) begin
            if (sizes >= 4'd1 && sizes <= 4'd6) begin
              m_ph = 1; m_n2 = int'(sizes) * int'(sizes);
              m_ra = 0; m_rb = 0; m_rc = 0; m_err = 1'b0;
            end else begin
              m_err = 1'b1;
            end
          end
        end
        1: begin
          if (ld_en) m_err = 1'b1;
          m_ph = 2;
        end
        default: begin
          if (ld_en) m_err = 1'b1;
          if (ren) begin
            if (raddr) begin m_rb++; if (m_rb > m_n2) m_err = 1'b1; end
            else       begin m_ra++; if (m_ra > m_n2) m_err = 1'b1; end
          end
          if (wen) begin
            if (m_rc < m_n2) begin m_r[m_rc] = wdata; m_rc++; end
            else m_err = 1'b1;
          end
          if (finish) begin
            m_ph = 3;
`ifdef MATRIX_HOST_PORT_CHECK_EN
            if (m_rc != m_n2 || m_ra < m_n2 - 1 || m_rb < m_n2 - 1) m_err = 1'b1;
`endif
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      logic [15:0] e_rd;
      logic [31:0] e_res;
      e_rd = 16'h0;
      if (ren) e_rd = raddr ? m_b[elem_of(m_rb, m_n2)] : m_a[elem_of(m_ra, m_n2)];
      e_res = (int'(res_addr) < 36) ? m_r[res_addr] : 32'h0;
      chk("start", {31'b0, start}, {31'b0, m_ph == 1});
      chk("busy",  {31'b0, busy},  {31'b0, m_ph == 1 || m_ph == 2});
      chk("done",  {31'b0, done},  {31'b0, m_ph == 3});
      chk("err",   {31'b0, err},   {31'b0, m_err});
      chk("res_count", {26'b0, res_count}, 32'(m_rc));
      chk("rdata", {16'b0, rdata}, {16'b0, e_rd});
      chk("res_data", res_data, e_res);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic sel, input int addr, input logic [15:0] data);
    ld_en = 1'b1; ld_sel = sel; ld_addr = 6'(addr); ld_data = data;
    cyc();
    ld_en = 1'b0;
  endtask

  task automatic launch(input int n);
    sizes = 4'(n); go = 1'b1;
    cyc();
    go = 1'b0;
    chk("launch_start", {31'b0, start}, 32'd1);
    cyc();
    chk("launch_run_start_low", {31'b0, start}, 32'd0);
    $display("launch N=%0d", n);
  endtask

  task automatic rd(input logic sel, input logic [15:0] exp);
    ren = 1'b1; raddr = sel;
    @(negedge clk);
    chk(sel ? "rd_b" : "rd_a", {16'b0, rdata}, {16'b0, exp});
    $display("read stream %0d data %0d", sel, $signed(rdata));
    @(posedge clk); #1;
    ren = 1'b0;
  endtask

  task automatic wr(input logic [31:0] data, input logic fin);
    wen = 1'b1; wdata = data; finish = fin;
    cyc();
    $display("result %0d finish %0b", $signed(data), fin);
    wen = 1'b0; finish = 1'b0;
  endtask

  task automatic run_2x2();
    logic [15:0] av [4];
    logic [15:0] bv [4];
    av = '{16'd1, 16'd2, 16'd3, 16'd4};
    bv = '{16'd1, 16'd0, 16'd0, 16'd1};
    for (int i = 0; i < 4; i++) ld(1'b0, i, av[i]);
    for (int i = 0; i < 4; i++) ld(1'b1, i, bv[i]);
    launch(2);
    for (int i = 0; i < 4; i++) rd(1'b0, av[i]);
    for (int i = 0; i < 4; i++) rd(1'b1, bv[i]);
    for (int i = 0; i < 3; i++) wr(32'(i + 1), 1'b0);
    wr(32'd4, 1'b1);
    chk("2x2_done", {31'b0, done}, 32'd1);
    chk("2x2_err", {31'b0, err}, 32'd0);
    chk("2x2_count", {26'b0, res_count}, 32'd4);
    res_addr = 6'd2; #1;
    chk("2x2_res2", res_data, 32'd3);
  endtask

  function automatic logic [31:0] wval(input int i);
    if (i % 2 == 0) return 32'(-32768 * 32767 + i);
    return 32'(32767 * 32767 - i);
  endfunction

  initial begin
    // reset state
    #12;
    ren = 1'b1;
    #1;
    chk("rst_start", {31'b0, start}, 32'd0);
    chk("rst_busy",  {31'b0, busy},  32'd0);
    chk("rst_done",  {31'b0, done},  32'd0);
    chk("rst_err",   {31'b0, err},   32'd0);
    chk("rst_count", {26'b0, res_count}, 32'd0);
    chk("rst_rdata", {16'b0, rdata}, 32'd0);
    chk("rst_res",   res_data, 32'd0);
    ren = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    cmp_on = 1'b1;
    cyc();

    // illegal sizes
    sizes = 4'd7; go = 1'b1; cyc(); go = 1'b0;
    chk("sz7_start", {31'b0, start}, 32'd0);
    chk("sz7_busy", {31'b0, busy}, 32'd0);
    chk("sz7_err", {31'b0, err}, 32'd1);
    sizes = 4'd0; go = 1'b1; cyc(); go = 1'b0;
    chk("sz0_busy", {31'b0, busy}, 32'd0);
    $display("illegal go sizes 7 and 0");

    // 2x2 identity run
    run_2x2();

    // overrun: 5 reads of A in a 2x2 run
    launch(2);
    rd(1'b0, 16'd1); rd(1'b0, 16'd2); rd(1'b0, 16'd3); rd(1'b0, 16'd4);
    chk("ovr_err_before", {31'b0, err}, 32'd0);
    rd(1'b0, 16'd4);
    chk("ovr_err", {31'b0, err}, 32'd1);
    ld(1'b0, 0, 16'hdead);   // ignored in RUN
    wr(32'd9, 1'b1);

    // result overflow at N=1
    launch(1);
    rd(1'b0, 16'd1); rd(1'b1, 16'd1);
    wr(32'd5, 1'b0);
    chk("n1_err_before", {31'b0, err}, 32'd0);
    wr(32'd6, 1'b1);
    chk("n1_err_drop", {31'b0, err}, 32'd1);
    chk("n1_count", {26'b0, res_count}, 32'd1);

    // N=6 full run with extreme signed values
    for (int i = 0; i < 36; i++) ld(1'b0, i, 16'(i * 3 + 1));
    for (int i = 0; i < 36; i++) ld(1'b1, i, 16'(-i));
    launch(6);
    for (int i = 0; i < 36; i++) begin
      rd(1'b0, 16'(i * 3 + 1));
      rd(1'b1, 16'(-i));
    end
    for (int i = 0; i < 35; i++) wr(wval(i), 1'b0);
    wr(wval(35), 1'b1);
    chk("n6_count", {26'b0, res_count}, 32'd36);
    chk("n6_err", {31'b0, err}, 32'd0);
    for (int i = 0; i < 36; i++) begin
      res_addr = 6'(i);
      cyc();
      chk("n6_res", res_data, wval(i));
    end
    res_addr = 6'd0; #1;
    chk("n6_res0_lit", res_data, 32'hC0008000);
    res_addr = 6'd1; #1;
    chk("n6_res1_lit", res_data, 32'h3FFF0000);

    // reset mid-run
    launch(2);
    rd(1'b0, 16'd1);
    wr(32'd77, 1'b0);
    #3;
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_count", {26'b0, res_count}, 32'd0);
    chk("mid_rst_err", {31'b0, err}, 32'd0);
    res_addr = 6'd0; #1;
    chk("mid_rst_res", res_data, 32'd0);
    $display("reset pulsed mid-run");
    @(posedge clk); #1;
    rstn = 1'b1;
    cyc();
    run_2x2();

    // short run: 3 of 4 results then finish
    launch(2);
    for (int i = 0; i < 4; i++) rd(1'b0, 16'(i + 1));
    rd(1'b1, 16'd1); rd(1'b1, 16'd0); rd(1'b1, 16'd0); rd(1'b1, 16'd1);
    for (int i = 0; i < 3; i++) wr(32'(10 + i), 1'b0);
    finish = 1'b1; cyc(); finish = 1'b0;
`ifdef MATRIX_HOST_PORT_CHECK_EN
    chk("short_err", {31'b0, err}, 32'd1);
`else
    chk("short_err", {31'b0, err}, 32'd0);
`endif
    chk("short_count", {26'b0, res_count}, 32'd3);

    cyc(); cyc();
    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
